// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: state encoding, default data width, index-width helper.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int ARB_STATE_W        = 3;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

  // Never narrower than one bit, so two-requester builds still get a usable index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit holds ptr+k before the explicit wrap, so non-power-of-2 counts work.
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant[cand[IDX_W-1:0]] = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; sequences enable/busy and holds tx_data per frame.
// Optional UART_ARB_PRIORITY_EN adds prio_mask: masked requesters win, round-robin inside each group.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUSY_TIMEOUT     = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data,
`ifdef UART_ARB_PRIORITY_EN
  input  logic [NUM_REQ-1:0]                  prio_mask,
`endif
  output logic [NUM_REQ-1:0]                  ack,
  output logic [NUM_REQ-1:0]                  done,
  output logic                                tx_enable,
  output logic [INPUT_DATA_WIDTH-1:0]         tx_data,
  input  logic                                tx_busy,
  output logic                                arb_busy,
  output logic                                timeout_err
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(BUSY_TIMEOUT);

  arb_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [INPUT_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                        timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

`ifdef UART_ARB_PRIORITY_EN
  logic [NUM_REQ-1:0] hi_req, hi_grant, lo_grant;
  logic [IDX_W-1:0]   hi_idx, lo_idx;
  logic               hi_any, lo_any;

  assign hi_req = req & prio_mask;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_hi (
    .req(hi_req), .ptr(rr_ptr_q), .grant(hi_grant), .idx(hi_idx), .any(hi_any)
  );
  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick_lo (
    .req(req), .ptr(rr_ptr_q), .grant(lo_grant), .idx(lo_idx), .any(lo_any)
  );

  assign pick_grant = hi_any ? hi_grant : lo_grant;
  assign pick_idx   = hi_any ? hi_idx   : lo_idx;
  assign pick_any   = lo_any;
`else
  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req), .ptr(rr_ptr_q), .grant(pick_grant), .idx(pick_idx), .any(pick_any)
  );
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = timeout_err_q;
    ack           = '0;
    done          = '0;
    tx_enable     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_busy) begin
          idx_d     = pick_idx;
          tx_data_d = req_data[pick_idx*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
          ack       = pick_grant;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Never fire enable into a UART that already reports busy.
        tx_enable = !tx_busy;
        cnt_d     = '0;
        state_d   = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (tx_busy) begin
          state_d = ST_WAIT_FALL;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT-1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_FALL: begin
        if (!tx_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        done[idx_q] = 1'b1;
        rr_ptr_d    = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pulses are suppressed in the reset cycle so an aborted frame never reports.
    if (reset) begin
      ack       = '0;
      done      = '0;
      tx_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign arb_busy    = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;

endmodule
